// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
// The slave side is the stage itself; the master side drives the EX/MEM fields.
interface mem_stage_if;
  logic        Stall_In;
  logic        MemRead_In;
  logic        MemWrite_In;
  logic [1:0]  ByteSel_In;
  logic [31:0] ALUResult_In;
  logic [31:0] Instruction_In;
  logic [1:0]  MemToReg_In;
  logic [31:0] PC_In;
  logic [4:0]  RegDest_In;
  logic        RegWrite_In;
  logic [31:0] WriteData_In;

  logic [31:0] ReadData_Out;
  logic [31:0] ALUResult_Out;
  logic [1:0]  MemToReg_Out;
  logic [31:0] PC_Out;
  logic [4:0]  RegDest_Out;
  logic        RegWrite_Out;
  logic        AddrError_Out;

  modport master (
    output Stall_In, MemRead_In, MemWrite_In, ByteSel_In, ALUResult_In, Instruction_In,
           MemToReg_In, PC_In, RegDest_In, RegWrite_In, WriteData_In,
    input  ReadData_Out, ALUResult_Out, MemToReg_Out, PC_Out, RegDest_Out, RegWrite_Out,
           AddrError_Out
  );

  modport slave (
    input  Stall_In, MemRead_In, MemWrite_In, ByteSel_In, ALUResult_In, Instruction_In,
           MemToReg_In, PC_In, RegDest_In, RegWrite_In, WriteData_In,
    output ReadData_Out, ALUResult_Out, MemToReg_Out, PC_Out, RegDest_Out, RegWrite_Out,
           AddrError_Out
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: byte/halfword/word loads and stores on an internal RAM,
// with the MEM/WB pipeline register folded in.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_BITS   = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  mem_stage_if.slave bus
);

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           lane;
  logic                 is_half;
  logic                 is_byte;
  logic                 is_word;
  logic                 misaligned;
  logic                 mem_we;
  logic [31:0]          rd_word;
  logic [31:0]          wr_word;
  logic [31:0]          load_d;
  logic [15:0]          half_sel;
  logic [7:0]           byte_sel;

  logic [31:0] read_data_q;
  logic [31:0] alu_result_q;
  logic [1:0]  mem_to_reg_q;
  logic [31:0] pc_q;
  logic [4:0]  reg_dest_q;
  logic        reg_write_q;
  logic        addr_error_q;

  // Only bit 28 of the instruction (unsigned-load flag) matters here.
  logic unused_instr;
  assign unused_instr = ^{bus.Instruction_In[31:29], bus.Instruction_In[27:0]};

  assign idx     = bus.ALUResult_In[ADDR_BITS+1:2];
  assign lane    = bus.ALUResult_In[1:0];
  assign is_half = (bus.ByteSel_In == 2'b01);
  assign is_byte = (bus.ByteSel_In == 2'b10);
  assign is_word = !is_half && !is_byte;

  assign misaligned = (bus.MemRead_In || bus.MemWrite_In) &&
                      ((is_half && lane[0]) || (is_word && (lane != 2'b00)));

  assign rd_word = mem_q[idx];

  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];

  always_comb begin
    load_d = '0;
    if (bus.MemRead_In && !misaligned) begin
      if (is_half) begin
        load_d = bus.Instruction_In[28] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end else if (is_byte) begin
        load_d = bus.Instruction_In[28] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end else begin
        load_d = rd_word;
      end
    end
  end

  // Merge store data into the current word so untouched lanes are preserved.
  always_comb begin
    wr_word = rd_word;
    if (is_half) begin
      if (lane[1]) begin
        wr_word[31:16] = bus.WriteData_In[15:0];
      end else begin
        wr_word[15:0] = bus.WriteData_In[15:0];
      end
    end else if (is_byte) begin
      wr_word[{lane, 3'b000} +: 8] = bus.WriteData_In[7:0];
    end else begin
      wr_word = bus.WriteData_In;
    end
  end

  assign mem_we = bus.MemWrite_In && !misaligned && !bus.Stall_In && !Reset;

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[idx] <= wr_word;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      mem_to_reg_q <= '0;
      pc_q         <= '0;
      reg_dest_q   <= '0;
      reg_write_q  <= 1'b0;
      addr_error_q <= 1'b0;
    end else if (!bus.Stall_In) begin
      read_data_q  <= load_d;
      alu_result_q <= bus.ALUResult_In;
      mem_to_reg_q <= bus.MemToReg_In;
      pc_q         <= bus.PC_In;
      reg_dest_q   <= bus.RegDest_In;
      reg_write_q  <= bus.RegWrite_In && !misaligned;
      addr_error_q <= misaligned;
    end
  end

  assign bus.ReadData_Out  = read_data_q;
  assign bus.ALUResult_Out = alu_result_q;
  assign bus.MemToReg_Out  = mem_to_reg_q;
  assign bus.PC_Out        = pc_q;
  assign bus.RegDest_Out   = reg_dest_q;
  assign bus.RegWrite_Out  = reg_write_q;
  assign bus.AddrError_Out = addr_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single-cycle accesses plus
// hand-written reset and stall sequences.
module tb_mem_stage;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH_WORDS(1024),
    .ADDR_BITS  (10)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  bsel;
    logic [31:0] addr;
    logic        uns;
    logic        rw_in;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic rd, input logic wr, input logic [1:0] bsel,
                     input logic [31:0] addr, input logic uns, input logic rw_in,
                     input logic [31:0] wdata, input logic [31:0] exp_data,
                     input logic exp_rw, input logic exp_err);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.bsel = bsel; v.addr = addr; v.uns = uns;
    v.rw_in = rw_in; v.wdata = wdata; v.exp_data = exp_data; v.exp_rw = exp_rw;
    v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic rd, input logic wr, input logic [1:0] bsel,
                       input logic [31:0] addr, input logic uns, input logic rw_in,
                       input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd_dst,
                       input logic [1:0] m2r);
    bus.Stall_In       = stall;
    bus.MemRead_In     = rd;
    bus.MemWrite_In    = wr;
    bus.ByteSel_In     = bsel;
    bus.ALUResult_In   = addr;
    bus.Instruction_In = {3'b000, uns, 28'h0000013};
    bus.RegWrite_In    = rw_in;
    bus.WriteData_In   = wdata;
    bus.PC_In          = pc;
    bus.RegDest_In     = rd_dst;
    bus.MemToReg_In    = m2r;
  endtask

  // One unstalled access, then compare all outputs #1 after the edge.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [1:0] bsel, input logic [31:0] addr, input logic uns,
                        input logic rw_in, input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_rw, input logic exp_err);
    drive(1'b0, rd, wr, bsel, addr, uns, rw_in, wdata, 32'hA000_0000 ^ addr, addr[6:2], addr[1:0]);
    @(posedge Clock);
    #1;
    chk({name, ".data"}, bus.ReadData_Out, exp_data);
    chk({name, ".rw"}, {31'b0, bus.RegWrite_Out}, {31'b0, exp_rw});
    chk({name, ".err"}, {31'b0, bus.AddrError_Out}, {31'b0, exp_err});
    chk({name, ".alu"}, bus.ALUResult_Out, addr);
    chk({name, ".pc"}, bus.PC_Out, 32'hA000_0000 ^ addr);
    chk({name, ".dst"}, {27'b0, bus.RegDest_Out}, {27'b0, addr[6:2]});
    chk({name, ".m2r"}, {30'b0, bus.MemToReg_Out}, {30'b0, addr[1:0]});
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".data"}, bus.ReadData_Out, 32'h0);
    chk({name, ".alu"}, bus.ALUResult_Out, 32'h0);
    chk({name, ".pc"}, bus.PC_Out, 32'h0);
    chk({name, ".ctl"}, {24'b0, bus.MemToReg_Out, bus.RegDest_Out, bus.RegWrite_Out},
        32'h0);
    chk({name, ".err"}, {31'b0, bus.AddrError_Out}, 32'h0);
  endtask

  task automatic chk_frozen(input string name);
    chk({name, ".data"}, bus.ReadData_Out, 32'hDEADBEEF);
    chk({name, ".alu"}, bus.ALUResult_Out, 32'h10);
    chk({name, ".pc"}, bus.PC_Out, 32'hA000_0010);
    chk({name, ".rw"}, {31'b0, bus.RegWrite_Out}, 32'h1);
    chk({name, ".err"}, {31'b0, bus.AddrError_Out}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //  name        rd    wr    bsel   addr          u     rwi   wdata         exp_data      rw    err
    add("sw10",    1'b0, 1'b1, 2'b00, 32'h10,       1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    add("lw10",    1'b1, 1'b0, 2'b00, 32'h10,       1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    add("sb21",    1'b0, 1'b1, 2'b10, 32'h21,       1'b0, 1'b0, 32'hFFFF_FF80, 32'h0,       1'b0, 1'b0);
    add("lw20",    1'b1, 1'b0, 2'b00, 32'h20,       1'b0, 1'b1, 32'h0,        32'h0000_8000, 1'b1, 1'b0);
    add("lb21",    1'b1, 1'b0, 2'b10, 32'h21,       1'b0, 1'b1, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0);
    add("lbu21",   1'b1, 1'b0, 2'b10, 32'h21,       1'b1, 1'b1, 32'h0,        32'h0000_0080, 1'b1, 1'b0);
    add("sh22",    1'b0, 1'b1, 2'b01, 32'h22,       1'b0, 1'b0, 32'h5555_9234, 32'h0,       1'b0, 1'b0);
    add("lh22",    1'b1, 1'b0, 2'b01, 32'h22,       1'b0, 1'b1, 32'h0,        32'hFFFF_9234, 1'b1, 1'b0);
    add("lhu22",   1'b1, 1'b0, 2'b01, 32'h22,       1'b1, 1'b1, 32'h0,        32'h0000_9234, 1'b1, 1'b0);
    add("lh20",    1'b1, 1'b0, 2'b01, 32'h20,       1'b0, 1'b1, 32'h0,        32'hFFFF_8000, 1'b1, 1'b0);
    add("lb23",    1'b1, 1'b0, 2'b10, 32'h23,       1'b0, 1'b1, 32'h0,        32'hFFFF_FF92, 1'b1, 1'b0);
    add("lw20b",   1'b1, 1'b0, 2'b00, 32'h20,       1'b0, 1'b1, 32'h0,        32'h9234_8000, 1'b1, 1'b0);
    add("sw13",    1'b0, 1'b1, 2'b00, 32'h13,       1'b0, 1'b1, 32'h1234_5678, 32'h0,       1'b0, 1'b1);
    add("lw10b",   1'b1, 1'b0, 2'b00, 32'h10,       1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    add("lh11",    1'b1, 1'b0, 2'b01, 32'h11,       1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1);
    add("sh11",    1'b0, 1'b1, 2'b01, 32'h11,       1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,       1'b0, 1'b1);
    add("lw10c",   1'b1, 1'b0, 2'b00, 32'h10,       1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    add("bsel11",  1'b1, 1'b0, 2'b11, 32'h10,       1'b1, 1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
    add("bsel11m", 1'b1, 1'b0, 2'b11, 32'h12,       1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1);
    add("swwrap",  1'b0, 1'b1, 2'b00, 32'h1000,     1'b0, 1'b0, 32'h1111_1111, 32'h0,       1'b0, 1'b0);
    add("lw0",     1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1111_1111, 1'b1, 1'b0);
    add("sw40",    1'b0, 1'b1, 2'b00, 32'h40,       1'b0, 1'b0, 32'h1,        32'h0,        1'b0, 1'b0);
    add("rdwr40",  1'b1, 1'b1, 2'b00, 32'h40,       1'b0, 1'b1, 32'h2,        32'h1,        1'b1, 1'b0);
    add("lw40",    1'b1, 1'b0, 2'b00, 32'h40,       1'b0, 1'b1, 32'h0,        32'h2,        1'b1, 1'b0);
    add("nord",    1'b0, 1'b0, 2'b00, 32'h40,       1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0);
    add("sb8003",  1'b0, 1'b1, 2'b10, 32'hFFFF_8003, 1'b0, 1'b0, 32'h0000_00A5, 32'h0,      1'b0, 1'b0);
    add("lw0b",    1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 1'b1, 32'h0,        32'hA511_1111, 1'b1, 1'b0);

    // Reset with random traffic, including a store to 0x50.
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'($urandom), 1'b1, 2'b00, 32'h50, 1'($urandom), 1'b1, $urandom, $urandom,
            5'($urandom), 2'($urandom));
      @(posedge Clock);
      #1;
      chk_all_zero($sformatf("reset%0d", i));
    end
    Reset = 1'b0;
    access("lw50_after_reset", 1'b1, 1'b0, 2'b00, 32'h50, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);

    foreach (vq[i]) begin
      access(vq[i].name, vq[i].rd, vq[i].wr, vq[i].bsel, vq[i].addr, vq[i].uns, vq[i].rw_in,
             vq[i].wdata, vq[i].exp_data, vq[i].exp_rw, vq[i].exp_err);
    end

    // Stall: outputs hold the lw 0x10 result; neither store nor error registers.
    access("pre_stall", 1'b1, 1'b0, 2'b00, 32'h10, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h30, 1'b0, 1'b1, 32'h55, 32'h1234, 5'd7, 2'd3);
    @(posedge Clock);
    #1;
    chk_frozen("stall_sw");
    drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h33, 1'b0, 1'b1, 32'h55, 32'h5678, 5'd9, 2'd1);
    @(posedge Clock);
    #1;
    chk_frozen("stall_misalign");
    access("lw30_old", 1'b1, 1'b0, 2'b00, 32'h30, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    access("sw30", 1'b0, 1'b1, 2'b00, 32'h30, 1'b0, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0);
    access("lw30_new", 1'b1, 1'b0, 2'b00, 32'h30, 1'b0, 1'b1, 32'h0, 32'h55, 1'b1, 1'b0);

    // Reset mid-sequence, also beating a stall: the store in that cycle is dropped.
    Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h60, 1'b0, 1'b1, 32'h77, 32'h9999, 5'd3, 2'd2);
    @(posedge Clock);
    #1;
    chk_all_zero("reset_mid");
    Reset = 1'b0;
    access("lw60_dropped", 1'b1, 1'b0, 2'b00, 32'h60, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    access("lw10_persist", 1'b1, 1'b0, 2'b00, 32'h10, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1,
           1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
